sram_sp_clr: RTL and testbench
==============================

Name: sram_sp_clr

Overview:
- Parametrised single-port synchronous SRAM. Successor to the fixed 16x4 scratch RAM.
- Generalised in width and depth, with a selectable read-during-write mode and an optional output register stage.
- Contains a hardware clear engine. The engine sweeps every word to a known value after reset or on request, because the storage array itself is not reset.
- Used as local scratch or lookup storage behind small datapath FSMs.

Parameters:
- DATA_W, 8: word width in bits, >= 1.
- ADDR_W, 4: address width in bits.
- DEPTH, 16: number of words, 1 <= DEPTH <= 2**ADDR_W.
- RDW_MODE, 0: read-during-write to the same address. 0 = read-first (old data returned). 1 = write-first (new data returned).
- OUT_REG, 0: 0 gives read latency 1; 1 adds an output register, giving latency 2.
- CLR_VAL, 0: DATA_W-bit value written by the clear engine.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr_req  in  1  one-cycle pulse; starts a full clear sweep.
- busy  out  1  high while the clear sweep is in progress.
- write_en  in  1  write strobe.
- rd_en  in  1  read strobe.
- addr  in  ADDR_W  word address.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  read data.
- rd_valid  out  1  data_out holds the result of an accepted read.

Behaviour:
- Reset values (rst_n low): busy=1, data_out=0, rd_valid=0, sweep counter=0, OUT_REG pipeline stage=0.
- The array is not reset. Clearing is done by the sweep.
- FSM states: SWEEP, IDLE.
  - Reset enters SWEEP, so the sweep starts on the first rising edge after rst_n deasserts.
  - SWEEP writes CLR_VAL to address cnt, then increments cnt, once per cycle.
  - After writing DEPTH-1, the FSM goes to IDLE and busy falls. The sweep takes exactly DEPTH cycles.
  - IDLE with clr_req=1: cnt=0 and the FSM goes to SWEEP. busy rises the next cycle.
- While busy=1:
  - write_en and rd_en are ignored and no rd_valid is produced.
  - clr_req is ignored; the sweep is not restarted.
- rst_n asserted mid-sweep: async reset, then the sweep restarts from address 0.
- IDLE write: when write_en=1 and addr<DEPTH, mem[addr]<=data_in at the clock edge.
- IDLE read (rd_en=1):
  - OUT_REG=0: data_out and rd_valid update at the same edge (latency 1).
  - OUT_REG=1: one extra cycle (latency 2).
  - rd_valid is a one-cycle pulse per accepted read. Back-to-back reads give back-to-back rd_valid pulses.
- data_out holds its last value when no read is accepted.
- Read and write to the same address in the same cycle:
  - RDW_MODE=0: data_out returns the old word.
  - RDW_MODE=1: data_out returns data_in.
- Out-of-range addresses (addr>=DEPTH):
  - Writes are dropped.
  - Reads return all-zeros, with rd_valid asserted as normal.
- clr_req and write_en in the same IDLE cycle: the write completes first, then the sweep overwrites it.
- In-flight read when clr_req arrives (OUT_REG=1): it still completes with rd_valid.

Optional Feature:
- Macro SRAM_SP_CLR_BYTE_WR_EN.
- When defined:
  - Adds input port byte_we, width DATA_W/8.
  - A write updates only the bytes whose byte_we bit is 1, with byte i = data_in[8i+7:8i].
  - write_en=1 with byte_we=0 writes nothing.
  - DATA_W must be a multiple of 8; violating this is an elaboration error.
  - The sweep always writes all bytes.
- When undefined: no byte_we port; every write updates the full word.

Test Plan:
- Reset release, DEPTH=16: busy=1 for exactly 16 cycles. Then reading all 16 addresses returns CLR_VAL=0x00, with rd_valid 1 cycle after each rd_en.
- Write 0xA5 to addr 3, then read addr 3: data_out=0xA5 one cycle later (OUT_REG=0), or two cycles later (OUT_REG=1).
- mem[5]=0x11, then same-cycle write 0x22 and read at addr 5: RDW_MODE=0 returns 0x11; RDW_MODE=1 returns 0x22. A following read returns 0x22.
- Fill addr 0..15 with 0xFF, pulse clr_req: busy=1 for 16 cycles. Writes issued during busy are ignored, and every address reads 0x00 afterwards.
- rst_n pulsed low at sweep cycle 7: all outputs go to reset values, then the sweep lasts a full 16 cycles.
- BYTE_WR_EN, DATA_W=16: mem[2]=0x1234, write 0xABCD with byte_we=2'b10 -> reads 0xAB34.

Source files
------------

// File: rtl/sram_sp_clr.sv
// sram_sp_clr: parametrised single-port synchronous SRAM with a hardware
// clear engine.
//
// The storage array has no reset. After reset, or on a clr_req pulse while
// idle, a two-state FSM (SWEEP/IDLE) writes CLR_VAL to every word, one word
// per cycle. The sweep takes exactly DEPTH cycles, and busy is high for that
// whole time. While busy is high, user reads, writes and clr_req are ignored.
//
// Handshake: there is no back-pressure.
//   - An accepted read is rd_en=1 while idle.
//   - Each accepted read produces exactly one rd_valid pulse.
//   - The pulse arrives 1 cycle after the read (OUT_REG=0) or 2 cycles
//     after it (OUT_REG=1).
//   - data_out holds its last value between pulses.
//   - A read of an address >= DEPTH returns zero, with a normal rd_valid.
//   - A write to an address >= DEPTH is dropped.
//
// Optional feature: define SRAM_SP_CLR_BYTE_WR_EN to add a byte_we port.
// A write then updates only the bytes whose byte_we bit is set. DATA_W must
// be a multiple of 8 when the feature is enabled.
module sram_sp_clr #(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 4,
  parameter int                 DEPTH    = 16,
  parameter int                 RDW_MODE = 0,
  parameter int                 OUT_REG  = 0,
  parameter logic [DATA_W-1:0]  CLR_VAL  = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_req,
  output logic                busy,
  input  logic                write_en,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data_in,
`ifdef SRAM_SP_CLR_BYTE_WR_EN
  input  logic [DATA_W/8-1:0] byte_we,
`endif
  output logic [DATA_W-1:0]   data_out,
  output logic                rd_valid
);

  // Number of address bits needed to index the physical array.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Last address written by the sweep.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // DEPTH with one extra bit, so that addr can be compared against it
  // without overflow when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W + 1)'(DEPTH);

  // Elaboration-time parameter sanity checks.
  if (DATA_W < 1) begin : g_bad_data_w
    $error("sram_sp_clr: DATA_W must be >= 1");
  end
  if ((DEPTH < 1) || (DEPTH > (1 << ADDR_W))) begin : g_bad_depth
    $error("sram_sp_clr: DEPTH must be in 1..2**ADDR_W");
  end
  if ((RDW_MODE != 0) && (RDW_MODE != 1)) begin : g_bad_rdw
    $error("sram_sp_clr: RDW_MODE must be 0 or 1");
  end
  if ((OUT_REG != 0) && (OUT_REG != 1)) begin : g_bad_out_reg
    $error("sram_sp_clr: OUT_REG must be 0 or 1");
  end

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]   cnt_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Shared write port. The sweep and user writes are multiplexed onto it.
  logic                mem_we;
  logic [IDX_W-1:0]    mem_widx;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_wmask;

  logic                rd_accept;
  logic                addr_in_range;
  logic [IDX_W-1:0]    addr_idx;
  logic [DATA_W-1:0]   user_mask;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   cur_word;

  logic                s1_valid_q;
  logic [DATA_W-1:0]   s1_data_q;

  assign addr_in_range = ({1'b0, addr} < DEPTH_CMP);
  assign addr_idx      = addr[IDX_W-1:0];

`ifdef SRAM_SP_CLR_BYTE_WR_EN
  if ((DATA_W % 8) != 0) begin : g_bad_byte_w
    $error("sram_sp_clr: DATA_W must be a multiple of 8 with byte enables");
  end
  // Expand each byte enable to a full 8-bit lane of the write mask.
  for (genvar g = 0; g < DATA_W / 8; g++) begin : g_byte_mask
    assign user_mask[g*8 +: 8] = {8{byte_we[g]}};
  end
`else
  assign user_mask = '1;
`endif

  // State and sweep counter; reset starts a sweep from address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic, and the write-port and read-accept steering.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy      = 1'b0;
    mem_we    = 1'b0;
    mem_widx  = addr_idx;
    mem_wdata = data_in;
    mem_wmask = user_mask;
    rd_accept = 1'b0;
    case (state_q)
      SWEEP: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_widx  = cnt_q[IDX_W-1:0];
        mem_wdata = CLR_VAL;
        mem_wmask = '1;
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        // A write in the same cycle as clr_req still lands. The sweep
        // then overwrites it.
        mem_we    = write_en && addr_in_range;
        rd_accept = rd_en;
        if (clr_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = SWEEP;
        cnt_d   = '0;
      end
    endcase
  end

  // Storage array: a masked write. No reset, because the sweep clears it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= (mem[mem_widx] & ~mem_wmask) | (mem_wdata & mem_wmask);
    end
  end

  // Read-data selection: out-of-range reads give zero, and write-first
  // mode forwards the merged write word.
  always_comb begin
    cur_word = mem[addr_idx];
    rd_word  = '0;
    if (addr_in_range) begin
      rd_word = cur_word;
      if ((RDW_MODE == 1) && mem_we) begin
        rd_word = (cur_word & ~mem_wmask) | (mem_wdata & mem_wmask);
      end
    end
  end

  // First read stage: capture the word on an accepted read, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_accept;
      if (rd_accept) begin
        s1_data_q <= rd_word;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                s2_valid_q;
    logic [DATA_W-1:0]   s2_data_q;

    // Optional output stage. It keeps running during a sweep, so an
    // in-flight read still completes.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign data_out = s2_data_q;
    assign rd_valid = s2_valid_q;
  end else begin : g_no_out_reg
    assign data_out = s1_data_q;
    assign rd_valid = s1_valid_q;
  end

endmodule

// File: tb/tb_sram_sp_clr.sv
// tb_sram_sp_clr: directed bench for sram_sp_clr (DEPTH=16, ADDR_W=5, so
// addresses 16..31 are out of range).
module tb_sram_sp_clr;

  localparam int          DATA_W   = 8;
  localparam int          ADDR_W   = 5;
  localparam int          DEPTH    = 16;
  localparam int          RDW_MODE = 0;
  localparam int          OUT_REG  = 0;
  localparam logic [7:0]  CLR_VAL  = 8'h00;
  localparam int          LAT      = (OUT_REG != 0) ? 2 : 1;

  logic              clk;
  logic              rst_n;
  logic              clr_req;
  logic              busy;
  logic              write_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
`ifdef SRAM_SP_CLR_BYTE_WR_EN
  logic [DATA_W/8-1:0] byte_we;
`endif

  int tests  = 0;
  int failed = 0;

  sram_sp_clr #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RDW_MODE (RDW_MODE),
    .OUT_REG  (OUT_REG),
    .CLR_VAL  (CLR_VAL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .write_en (write_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .data_in  (data_in),
`ifdef SRAM_SP_CLR_BYTE_WR_EN
    .byte_we  (byte_we),
`endif
    .data_out (data_out),
    .rd_valid (rd_valid)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input logic [7:0] d);
    write_en = 1'b1;
    addr     = ADDR_W'(a);
    data_in  = d;
    tick();
    write_en = 1'b0;
  endtask

  task automatic read_check(input string tag, input int a, input logic [7:0] exp);
    rd_en = 1'b1;
    addr  = ADDR_W'(a);
    tick();
    rd_en = 1'b0;
    repeat (LAT - 1) tick();
    check({tag, "_valid"}, {31'b0, rd_valid}, 32'd1);
    check({tag, "_data"}, {24'b0, data_out}, {24'b0, exp});
  endtask

  // Count the cycles for which busy stays high, with a bound.
  task automatic wait_sweep(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int         n;
    int         e;
    int         bad;
    logic [7:0] infl;
    logic       v_obs [4];
    logic [7:0] d_obs [4];

    rst_n    = 1'b1;
    clr_req  = 1'b0;
    write_en = 1'b0;
    rd_en    = 1'b0;
    addr     = '0;
    data_in  = '0;
    infl     = '0;
`ifdef SRAM_SP_CLR_BYTE_WR_EN
    byte_we  = '1;
`endif
    #2 rst_n = 1'b0;
    #2;
    check("rst_busy", {31'b0, busy}, 32'd1);
    check("rst_data_out", {24'b0, data_out}, 32'd0);
    check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);

    // Reset release: the sweep lasts DEPTH cycles.
    repeat (3) tick();
    rst_n = 1'b1;
    wait_sweep(n);
    check("init_sweep_len", n, DEPTH);

    for (int i = 0; i < DEPTH; i++) read_check("init_clr", i, CLR_VAL);
    tick();
    check("rd_valid_pulse", {31'b0, rd_valid}, 32'd0);

    // Basic write then read.
    write_word(3, 8'hA5);
    read_check("wr_rd_3", 3, 8'hA5);

    // Read during write to the same address.
    write_word(5, 8'h11);
    write_en = 1'b1;
    rd_en    = 1'b1;
    addr     = 5'd5;
    data_in  = 8'h22;
    tick();
    write_en = 1'b0;
    rd_en    = 1'b0;
    repeat (LAT - 1) tick();
    check("rdw_valid", {31'b0, rd_valid}, 32'd1);
    check("rdw_data", {24'b0, data_out}, (RDW_MODE == 1) ? 32'h22 : 32'h11);
    read_check("rdw_after", 5, 8'h22);

    // Back-to-back reads: addr 3 then addr 5; data_out held 0x22 beforehand.
    rd_en = 1'b1;
    addr  = 5'd3;
    tick();
    v_obs[0] = rd_valid; d_obs[0] = data_out;
    addr  = 5'd5;
    tick();
    v_obs[1] = rd_valid; d_obs[1] = data_out;
    rd_en = 1'b0;
    tick();
    v_obs[2] = rd_valid; d_obs[2] = data_out;
    tick();
    v_obs[3] = rd_valid; d_obs[3] = data_out;
    for (int i = 0; i < 4; i++) begin
      check("b2b_valid", {31'b0, v_obs[i]}, ((i == LAT - 1) || (i == LAT)) ? 32'd1 : 32'd0);
      check("b2b_data", {24'b0, d_obs[i]}, (i == LAT - 1) ? 32'hA5 : 32'h22);
    end

    // Out-of-range write is dropped and does not alias; the read gives zero.
    write_word(20, 8'h99);
    read_check("oor_read", 20, 8'h00);
    read_check("oor_alias", 4, CLR_VAL);

`ifdef SRAM_SP_CLR_BYTE_WR_EN
    write_word(2, 8'h12);
    byte_we = 1'b0;
    write_word(2, 8'hAB);
    byte_we = 1'b1;
    read_check("byte_we_zero", 2, 8'h12);
`endif

    // data_out holds between reads, even across an unrelated write.
    read_check("hold_setup", 3, 8'hA5);
    write_word(7, 8'h3D);
    tick();
    check("hold_data", {24'b0, data_out}, 32'hA5);
    check("hold_valid", {31'b0, rd_valid}, 32'd0);

    // Clear request. The clr cycle also carries a write and a read of addr 3.
    // Requests made while busy are ignored.
    for (int i = 0; i < DEPTH; i++) write_word(i, 8'hFF);
    clr_req  = 1'b1;
    write_en = 1'b1;
    rd_en    = 1'b1;
    addr     = 5'd3;
    data_in  = 8'h3C;
    tick();
    e        = 1;
    clr_req  = 1'b0;
    addr     = 5'd6;
    data_in  = 8'h55;
    bad      = 0;
    n        = 0;
    while (busy === 1'b1 && n < 100) begin
      if (rd_valid !== (e == LAT)) bad++;
      if (e == LAT) infl = data_out;
      clr_req = (e == 5);
      tick();
      e++;
      n++;
    end
    clr_req  = 1'b0;
    write_en = 1'b0;
    rd_en    = 1'b0;
    check("clr_sweep_len", n, DEPTH);
    check("clr_busy_valid", bad, 0);
    check("clr_inflight", {24'b0, infl}, (RDW_MODE == 1) ? 32'h3C : 32'hFF);
    for (int i = 0; i < DEPTH; i++) read_check("clr_read", i, CLR_VAL);

    // Reset asserted at sweep cycle 7.
    write_word(1, 8'h5A);
    read_check("pre_rst", 1, 8'h5A);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'd1);
    check("mid_rst_data", {24'b0, data_out}, 32'd0);
    check("mid_rst_valid", {31'b0, rd_valid}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    wait_sweep(n);
    check("mid_rst_sweep_len", n, DEPTH);
    read_check("mid_rst_read", 1, CLR_VAL);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
